des_key_schedule_iterative: RTL

Iterative DES key schedule that feeds the Kn input of the pipelined round-function chain. It accepts one 64-bit key, applies PC-1, and then emits one 48-bit round subkey per accepted handshake, tagged with its round index. It supports encrypt order (K1..KN) and decrypt order (KN..K1), and a reduced round count for reduced-round DES experiments.

---
 rtl/des_key_schedule_iterative_pkg.sv | 68 ++++++
 rtl/des_key_schedule_iterative_pc2.sv | 17 +
 rtl/des_key_schedule_iterative.sv | 110 +++++++++++
 3 files changed

// File: rtl/des_key_schedule_iterative_pkg.sv
// DES key-schedule constants: PC-1/PC-2 index tables, shift tables,
// widths, FSM state type and 28-bit rotate helpers.
package des_key_schedule_iterative_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;

    // Key bit (1 = MSB) feeding each PC-1 output position 1..56.
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // {C,D} bit (1 = MSB) feeding each PC-2 output position 1..48.
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Entry i is the shift of subkey K(i+1).
    localparam logic [4:0] SH [0:15] = '{
        5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2,
        5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd1
    };

    // Entry i is the total rotation applied to reach K(i+1).
    localparam logic [4:0] CUM [0:15] = '{
        5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
        5'd15, 5'd17, 5'd19, 5'd21, 5'd23, 5'd25, 5'd27, 5'd28
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [CD_W-1:0] rotl28(
        input logic [CD_W-1:0] x,
        input logic [4:0]      n
    );
        logic [2*CD_W-1:0] t;
        t = {x, x} << n;
        return t[2*CD_W-1:CD_W];
    endfunction

    function automatic logic [CD_W-1:0] rotr28(
        input logic [CD_W-1:0] x,
        input logic [4:0]      n
    );
        logic [2*CD_W-1:0] t;
        t = {x, x} >> n;
        return t[CD_W-1:0];
    endfunction

endpackage

// File: rtl/des_key_schedule_iterative_pc2.sv
// PC-2 permutation: compresses the 56-bit {C,D} state to a 48-bit subkey.
// Ports: cd [1:56] in (bit 1 = MSB), k [1:48] out.
module pc2_permutation
    import des_key_schedule_iterative_pkg::*;
(
    input  logic [1:2*CD_W]   cd,
    output logic [1:SUBKEY_W] k
);

    always_comb begin
        k = '0;
        for (int i = 1; i <= SUBKEY_W; i++) begin
            k[i] = cd[PC2[i-1]];
        end
    end

endmodule

// File: rtl/des_key_schedule_iterative.sv
// Iterative DES key schedule: accepts one key, emits N_ROUNDS subkeys
// in encrypt (K1..KN) or decrypt (KN..K1) order over a valid/ready link.
// Ports: clk, rst (async, high); key side i_valid/o_ready/key_in/i_decrypt;
// subkey side o_valid/i_ready/Kn/round_o/o_last.
module des_key_schedule_iterative
    import des_key_schedule_iterative_pkg::*;
#(
    parameter int N_ROUNDS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:KEY_W]      key_in,
    input  logic                i_decrypt,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [1:SUBKEY_W]   Kn,
    output logic [3:0]          round_o,
    output logic                o_last
);

    if (N_ROUNDS < 1 || N_ROUNDS > 16) begin : g_bad_rounds
        $error("des_key_schedule_iterative: N_ROUNDS must be 1..16");
    end

    localparam int         NR_IDX  = (N_ROUNDS >= 1 && N_ROUNDS <= 16)
                                     ? N_ROUNDS - 1 : 0;
    localparam logic [3:0] LAST    = 4'(NR_IDX);
    // Decrypt starts at KN, i.e. the full cumulative rotation (28 == 0).
    localparam logic [4:0] DEC_ROT = 5'(CUM[NR_IDX] % 5'd28);

    state_t            state;
    logic [CD_W-1:0]   c;
    logic [CD_W-1:0]   d;
    logic [3:0]        cnt;
    logic              dir;

    logic [1:2*CD_W]   pc1_out;
    logic [CD_W-1:0]   c0;
    logic [CD_W-1:0]   d0;
    logic [4:0]        rot0;
    logic [3:0]        sh_idx;
    logic [4:0]        sh_amt;

    always_comb begin
        pc1_out = '0;
        for (int i = 1; i <= 2*CD_W; i++) begin
            pc1_out[i] = key_in[PC1[i-1]];
        end
    end

    assign {c0, d0} = pc1_out;
    assign rot0     = i_decrypt ? DEC_ROT : SH[0];

    // Encrypt moves to K(cnt+2); decrypt undoes the shift of the
    // subkey just emitted, K(N-cnt). Both are SH entry shown below.
    assign sh_idx = dir ? (LAST - cnt) : (cnt + 4'd1);
    assign sh_amt = SH[sh_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        c     <= rotl28(c0, rot0);
                        d     <= rotl28(d0, rot0);
                        cnt   <= '0;
                        dir   <= i_decrypt;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (i_ready) begin
                        if (cnt == LAST) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 4'd1;
                            if (dir) begin
                                c <= rotr28(c, sh_amt);
                                d <= rotr28(d, sh_amt);
                            end else begin
                                c <= rotl28(c, sh_amt);
                                d <= rotl28(d, sh_amt);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == RUN);
    assign o_last  = o_valid && (cnt == LAST);
    assign round_o = dir ? (LAST - cnt) : cnt;

    pc2_permutation u_pc2 (
        .cd ({c, d}),
        .k  (Kn)
    );

endmodule
